// File: rtl/nim_turn_ctrl.sv
// Nim game sequencer: three heaps, alternating turns, move validation and score strobes.
// Define NIM_MISERE_EN for misère play (the last taker loses).
module nim_turn_ctrl #(
    parameter int HEAP_W     = 4,
    parameter int HEAP0_INIT = 3,
    parameter int HEAP1_INIT = 5,
    parameter int HEAP2_INIT = 7,
    parameter int MAX_TAKE   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              move_req,
    input  logic [1:0]        heap_sel,
    input  logic [2:0]        take_cnt,
    output logic              move_ready,
    output logic              cur_player,
    output logic [HEAP_W-1:0] heap0,
    output logic [HEAP_W-1:0] heap1,
    output logic [HEAP_W-1:0] heap2,
    output logic              invalid_move,
    output logic              game_over,
    output logic              inc_lp,
    output logic              inc_rp,
    output logic              dec_lp,
    output logic              dec_rp
);

`ifdef NIM_MISERE_EN
    localparam logic MISERE = 1'b1;
`else
    localparam logic MISERE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_MOVE, CHECK, END_TEST, OVER} state_t;

    state_t            state;
    logic [1:0]        sel_q;
    logic [2:0]        take_q;
    logic [HEAP_W-1:0] heap_q [3];
    logic [HEAP_W-1:0] sel_heap;
    logic              illegal;
    logic              all_zero;
    logic              winner;

    assign heap0 = heap_q[0];
    assign heap1 = heap_q[1];
    assign heap2 = heap_q[2];

    always_comb begin
        sel_heap = '0;
        case (sel_q)
            2'd0:    sel_heap = heap_q[0];
            2'd1:    sel_heap = heap_q[1];
            2'd2:    sel_heap = heap_q[2];
            default: sel_heap = '0;
        endcase
        illegal = (take_q == '0) || (int'(take_q) > MAX_TAKE) ||
                  (sel_q == 2'd3) || (int'(take_q) > int'(sel_heap));
        all_zero = (heap_q[0] == '0) && (heap_q[1] == '0) && (heap_q[2] == '0);
        // Under misère the scorer is the opponent of the last taker.
        winner = cur_player ^ MISERE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            heap_q[0]    <= '0;
            heap_q[1]    <= '0;
            heap_q[2]    <= '0;
            sel_q        <= '0;
            take_q       <= '0;
            cur_player   <= 1'b0;
            move_ready   <= 1'b0;
            game_over    <= 1'b0;
            invalid_move <= 1'b0;
            inc_lp       <= 1'b0;
            inc_rp       <= 1'b0;
            dec_lp       <= 1'b0;
            dec_rp       <= 1'b0;
        end else begin
            invalid_move <= 1'b0;
            inc_lp       <= 1'b0;
            inc_rp       <= 1'b0;
            dec_lp       <= 1'b0;
            dec_rp       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    heap_q[0]  <= HEAP_W'(HEAP0_INIT);
                    heap_q[1]  <= HEAP_W'(HEAP1_INIT);
                    heap_q[2]  <= HEAP_W'(HEAP2_INIT);
                    cur_player <= 1'b0;
                    state      <= WAIT_MOVE;
                    move_ready <= 1'b1;
                end
                WAIT_MOVE: begin
                    if (start) begin
                        state      <= LOAD;
                        move_ready <= 1'b0;
                    end else if (move_req) begin
                        sel_q      <= heap_sel;
                        take_q     <= take_cnt;
                        state      <= CHECK;
                        move_ready <= 1'b0;
                    end
                end
                CHECK: begin
                    if (start) begin
                        state <= LOAD;
                    end else if (illegal) begin
                        invalid_move <= 1'b1;
                        dec_lp       <= ~cur_player;
                        dec_rp       <= cur_player;
                        state        <= WAIT_MOVE;
                        move_ready   <= 1'b1;
                    end else begin
                        case (sel_q)
                            2'd0:    heap_q[0] <= heap_q[0] - HEAP_W'(take_q);
                            2'd1:    heap_q[1] <= heap_q[1] - HEAP_W'(take_q);
                            default: heap_q[2] <= heap_q[2] - HEAP_W'(take_q);
                        endcase
                        state <= END_TEST;
                    end
                end
                END_TEST: begin
                    if (start) begin
                        state <= LOAD;
                    end else if (all_zero) begin
                        inc_lp    <= ~winner;
                        inc_rp    <= winner;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        cur_player <= ~cur_player;
                        move_ready <= 1'b1;
                        state      <= WAIT_MOVE;
                    end
                end
                OVER: begin
                    if (start) begin
                        game_over <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
